// File: rtl/ctu_clsp_dram_ckseq.sv
// DRAM-domain clock-enable sequencer: staggered turn-on aligned to the sync edge,
// reverse-order turn-off, with a programmable gap between steps to bound di/dt.
module ctu_clsp_dram_ckseq (
    input  logic       dram_gclk,
    input  logic       dram_arst,
    input  logic       start_pls,
    input  logic       stop_pls,
    input  logic       sync_edge,
    input  logic [5:0] cken_mask,
    input  logic [3:0] gap_cyc,
    input  logic       force_cken,
    output logic [5:0] cken_dg,
    output logic       seq_busy,
    output logic       seq_done
);

    typedef enum logic [2:0] {IDLE, ARM, ON_GAP, RUN, OFF_ARM, OFF_GAP} state_e;

    state_e     state_q;
    logic [3:0] cnt_q;
    logic [3:0] gap_q;
    logic [5:0] mask_q;
    logic [5:0] cken_q;
    logic       force_q;
    logic       done_q;

    logic [5:0] rem;
    logic [5:0] on_bit;
    logic [5:0] on_nxt;
    logic [5:0] off_nxt;
    logic       on_last;
    logic       off_last;

    // Bits turn on lowest-first, so the next one is the lowest enabled bit not yet set;
    // turn-off always removes the highest set bit.
    always_comb begin
        rem      = mask_q & ~cken_q;
        on_bit   = rem & (~rem + 6'd1);
        on_nxt   = cken_q | on_bit;
        on_last  = (rem & ~on_bit) == 6'd0;
        off_nxt  = cken_q;
        for (int i = 0; i < 6; i++)
            if (cken_q[i]) off_nxt = cken_q & ~(6'd1 << i);
        off_last = off_nxt == 6'd0;
    end

    always_ff @(posedge dram_gclk or posedge dram_arst) begin
        if (dram_arst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            gap_q   <= 4'd0;
            mask_q  <= 6'd0;
            cken_q  <= 6'd0;
            force_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            force_q <= force_cken;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: if (start_pls) begin
                    mask_q  <= cken_mask;
                    gap_q   <= gap_cyc;
                    state_q <= ARM;
                end
                ARM, ON_GAP: begin
                    if (stop_pls) begin
                        state_q <= (state_q == ARM) ? IDLE : OFF_ARM;
                    end else if (state_q == ON_GAP && cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (state_q == ON_GAP || sync_edge) begin
                        cken_q <= on_nxt;
                        cnt_q  <= gap_q;
                        if (on_last) begin
                            state_q <= RUN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ON_GAP;
                        end
                    end
                end
                RUN: if (stop_pls) state_q <= OFF_ARM;
                OFF_ARM, OFF_GAP: begin
                    if (state_q == OFF_GAP && cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (state_q == OFF_GAP || sync_edge) begin
                        cken_q <= off_nxt;
                        cnt_q  <= gap_q;
                        if (off_last) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= OFF_GAP;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cken_dg  = cken_q | {6{force_q}};
    assign seq_busy = (state_q == ARM) || (state_q == ON_GAP) ||
                      (state_q == OFF_ARM) || (state_q == OFF_GAP);
    assign seq_done = done_q;

endmodule

// File: tb/tb_ctu_clsp_dram_ckseq.sv
// Directed bench for the DRAM clock-enable sequencer; expected per-cycle outputs
// go through a scoreboard queue and are checked 1 ns after each rising edge.
module tb_ctu_clsp_dram_ckseq;

    logic       clk = 1'b0;
    logic       dram_arst;
    logic       start_pls, stop_pls, sync_edge, force_cken;
    logic [5:0] cken_mask;
    logic [3:0] gap_cyc;
    logic [5:0] cken_dg;
    logic       seq_busy, seq_done;

    typedef struct packed {
        logic [5:0] ck;
        logic       b;
        logic       d;
    } exp_t;

    exp_t       sb[$];
    logic [5:0] vs [6];
    int         n_chk  = 0;
    int         n_fail = 0;

    ctu_clsp_dram_ckseq dut (
        .dram_gclk (clk),
        .dram_arst (dram_arst),
        .start_pls (start_pls),
        .stop_pls  (stop_pls),
        .sync_edge (sync_edge),
        .cken_mask (cken_mask),
        .gap_cyc   (gap_cyc),
        .force_cken(force_cken),
        .cken_dg   (cken_dg),
        .seq_busy  (seq_busy),
        .seq_done  (seq_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input exp_t e);
        n_chk++;
        assert (cken_dg === e.ck) else begin
            n_fail++;
            $error("FAIL %s cken_dg got %h exp %h", tag, cken_dg, e.ck);
        end
        n_chk++;
        assert (seq_busy === e.b) else begin
            n_fail++;
            $error("FAIL %s seq_busy got %b exp %b", tag, seq_busy, e.b);
        end
        n_chk++;
        assert (seq_done === e.d) else begin
            n_fail++;
            $error("FAIL %s seq_done got %b exp %b", tag, seq_done, e.d);
        end
    endtask

    // Push the expectation for the cycle after this edge, clock, then pop and compare.
    task automatic go(input string tag, input logic [5:0] ck, input logic b, input logic d);
        exp_t e;
        sb.push_back({ck, b, d});
        @(posedge clk);
        #1;
        start_pls = 1'b0;
        stop_pls  = 1'b0;
        sync_edge = 1'b0;
        e = sb.pop_front();
        chk(tag, e);
    endtask

    // Walk vs[0..n-1], each step gap+1 cycles apart; last step ends busy with done.
    task automatic steps(input string tag, input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            if (k > 0) repeat (gap) go(tag, vs[k-1], 1'b1, 1'b0);
            go(tag, vs[k], k != n - 1, k == n - 1);
        end
    endtask

    initial begin
        dram_arst = 1'b0;
        start_pls = 1'b0; stop_pls = 1'b0; sync_edge = 1'b0; force_cken = 1'b0;
        cken_mask = 6'h00; gap_cyc = 4'd0;
        #2 dram_arst = 1'b1;
        #1 chk("reset", '0);
        @(posedge clk); #1;
        dram_arst = 1'b0;

        // Full mask, gap 2; mask/gap changed after acceptance must be ignored
        cken_mask = 6'h3F; gap_cyc = 4'd2;
        start_pls = 1'b1; go("on3f_arm", 6'h00, 1'b1, 1'b0);
        cken_mask = 6'h00; gap_cyc = 4'd7;
        go("on3f_wait", 6'h00, 1'b1, 1'b0);
        vs = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F};
        sync_edge = 1'b1; steps("on3f", 6, 2);
        go("run3f", 6'h3F, 1'b0, 1'b0);
        stop_pls = 1'b1; go("off3f_arm", 6'h3F, 1'b1, 1'b0);
        vs = '{6'h1F, 6'h0F, 6'h07, 6'h03, 6'h01, 6'h00};
        sync_edge = 1'b1; steps("off3f", 6, 2);
        go("idle3f", 6'h00, 1'b0, 1'b0);

        // Sparse mask, gap 0; start ignored in RUN; stop+sync in RUN does not step
        cken_mask = 6'b100101; gap_cyc = 4'd0;
        start_pls = 1'b1; go("on25_arm", 6'h00, 1'b1, 1'b0);
        vs = '{6'h01, 6'h05, 6'h25, 6'h00, 6'h00, 6'h00};
        sync_edge = 1'b1; steps("on25", 3, 0);
        start_pls = 1'b1; go("run_start_ign", 6'h25, 1'b0, 1'b0);
        stop_pls = 1'b1; sync_edge = 1'b1; go("run_stop_sync", 6'h25, 1'b1, 1'b0);
        go("offarm_hold", 6'h25, 1'b1, 1'b0);
        vs = '{6'h05, 6'h01, 6'h00, 6'h00, 6'h00, 6'h00};
        sync_edge = 1'b1; steps("off25", 3, 0);

        // Empty mask
        cken_mask = 6'h00; gap_cyc = 4'd5;
        start_pls = 1'b1; go("m0_arm", 6'h00, 1'b1, 1'b0);
        sync_edge = 1'b1; go("m0_run", 6'h00, 1'b0, 1'b1);
        go("m0_run2", 6'h00, 1'b0, 1'b0);
        stop_pls = 1'b1; go("m0_offarm", 6'h00, 1'b1, 1'b0);
        sync_edge = 1'b1; go("m0_idle", 6'h00, 1'b0, 1'b1);
        go("m0_idle2", 6'h00, 1'b0, 1'b0);

        // Abort turn-on in ON_GAP after two bits, gap 3
        cken_mask = 6'h3F; gap_cyc = 4'd3;
        start_pls = 1'b1; go("ab_arm", 6'h00, 1'b1, 1'b0);
        sync_edge = 1'b1; go("ab_on1", 6'h01, 1'b1, 1'b0);
        repeat (3) go("ab_gap", 6'h01, 1'b1, 1'b0);
        go("ab_on2", 6'h03, 1'b1, 1'b0);
        stop_pls = 1'b1; go("ab_offarm", 6'h03, 1'b1, 1'b0);
        go("ab_offarm2", 6'h03, 1'b1, 1'b0);
        vs = '{6'h01, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        sync_edge = 1'b1; steps("ab_off", 2, 3);
        go("ab_idle", 6'h00, 1'b0, 1'b0);

        // Stop in ARM wins over sync; start+stop in IDLE accepts start
        start_pls = 1'b1; go("sa_arm", 6'h00, 1'b1, 1'b0);
        stop_pls = 1'b1; sync_edge = 1'b1; go("sa_idle", 6'h00, 1'b0, 1'b0);
        go("sa_nodone", 6'h00, 1'b0, 1'b0);
        start_pls = 1'b1; stop_pls = 1'b1; go("ss_arm", 6'h00, 1'b1, 1'b0);
        stop_pls = 1'b1; go("ss_idle", 6'h00, 1'b0, 1'b0);
        stop_pls = 1'b1; go("idle_stop_ign", 6'h00, 1'b0, 1'b0);

        // Force override, alone and across a full sequence
        force_cken = 1'b1; go("frc_on", 6'h3F, 1'b0, 1'b0);
        force_cken = 1'b0; go("frc_off", 6'h00, 1'b0, 1'b0);
        force_cken = 1'b1; go("frc_on2", 6'h3F, 1'b0, 1'b0);
        cken_mask = 6'b100101; gap_cyc = 4'd0;
        start_pls = 1'b1; go("frc_arm", 6'h3F, 1'b1, 1'b0);
        vs = '{6'h3F, 6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00};
        sync_edge = 1'b1; steps("frc_seq", 3, 0);
        force_cken = 1'b0; go("frc_rel", 6'h25, 1'b0, 1'b0);
        stop_pls = 1'b1; go("frc_offarm", 6'h25, 1'b1, 1'b0);
        vs = '{6'h05, 6'h01, 6'h00, 6'h00, 6'h00, 6'h00};
        sync_edge = 1'b1; steps("frc_off", 3, 0);

        // Asynchronous reset mid turn-on
        cken_mask = 6'h3F; gap_cyc = 4'd2;
        start_pls = 1'b1; go("rst_arm", 6'h00, 1'b1, 1'b0);
        sync_edge = 1'b1; go("rst_on1", 6'h01, 1'b1, 1'b0);
        repeat (2) go("rst_gap", 6'h01, 1'b1, 1'b0);
        go("rst_on2", 6'h03, 1'b1, 1'b0);
        #2 dram_arst = 1'b1;
        #1 chk("rst_async", '0);
        start_pls = 1'b1; cken_mask = 6'b100101; gap_cyc = 4'd0;
        @(posedge clk); #1;
        chk("rst_held", '0);
        dram_arst = 1'b0;
        go("rst_start", 6'h00, 1'b1, 1'b0);
        vs = '{6'h01, 6'h05, 6'h25, 6'h00, 6'h00, 6'h00};
        sync_edge = 1'b1; steps("rst_seq", 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
